// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and constants: FSM state encoding, prefix codes
// and the odd-parity helper used by the frame decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
  localparam int         PS2_DATA_BITS  = 8;

  // True when the data byte plus its parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer plus FILTER_LEN-sample glitch filter for one PS/2 line.
// All stages preset to 1 (idle line) on reset so no false edge follows reset.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic din_i,
  output logic dout_o
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  dout_q;
  logic                  dout_d;

  // Synchronizer, sample history and accepted level registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b11;
      hist_q <= {FILTER_LEN{1'b1}};
      dout_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], din_i};
      hist_q <= FILTER_LEN'({hist_q, sync_q[1]});
      dout_q <= dout_d;
    end
  end

  // A new level is accepted only once the whole history agrees on it.
  always_comb begin
    dout_d = dout_q;
    if (&hist_q) begin
      dout_d = 1'b1;
    end else if (~|hist_q) begin
      dout_d = 1'b0;
    end else begin
      dout_d = dout_q;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: filters the lines, decodes 11-bit frames and
// folds F0/E0 prefixes into flags. Define PS2_RX_TIMEOUT_EN for the stall timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       scan_break,
  output logic       scan_ext,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  if (CLK_HZ < 1 || FILTER_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ps2_frame_rx: CLK_HZ, FILTER_LEN and TIMEOUT_CYCLES must be positive");
  end

  localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic clk_f_s;
  logic data_f_s;
  logic fall_s;
  logic timeout_s;

  ps2_state_e               state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic                     par_bit_q, par_bit_d;
  logic                     brk_pend_q, brk_pend_d;
  logic                     ext_pend_q, ext_pend_d;
  logic                     clk_prev_q;
  logic [7:0]               code_q, code_d;
  logic                     sbrk_q, sbrk_d;
  logic                     sext_q, sext_d;
  logic                     valid_q, valid_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     busy_q;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .din_i   (ps2_clk),
    .dout_o  (clk_f_s)
  );

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .din_i   (ps2_data),
    .dout_o  (data_f_s)
  );

  assign fall_s = clk_prev_q & ~clk_f_s;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int                TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]   TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Cycles since the last falling edge, only while a frame is in progress.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (fall_s || (state_q == IDLE)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_s = (state_q != IDLE) && (to_cnt_q == TO_MAX);
`else
  assign timeout_s = 1'b0;
`endif

  // Frame FSM, prefix tracking and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    brk_pend_d = brk_pend_q;
    ext_pend_d = ext_pend_q;
    code_d     = code_q;
    sbrk_d     = sbrk_q;
    sext_d     = sext_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    if (fall_s) begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = 3'd0;
          if (!data_f_s) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          shift_d = {data_f_s, shift_q[PS2_DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = PARITY;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
          par_bit_d = data_f_s;
          state_d   = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // Stop-bit failure takes precedence so at most one strobe fires.
          if (!data_f_s) begin
            ferr_d     = 1'b1;
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
          end else if (!odd_parity_ok(shift_q, par_bit_q)) begin
            perr_d     = 1'b1;
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
          end else if (shift_q == PS2_BREAK_CODE) begin
            brk_pend_d = 1'b1;
          end else if (shift_q == PS2_EXT_CODE) begin
            ext_pend_d = 1'b1;
          end else begin
            code_d     = shift_q;
            sbrk_d     = brk_pend_q;
            sext_d     = ext_pend_q;
            valid_d    = 1'b1;
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if (timeout_s) begin
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      ferr_d     = 1'b1;
      brk_pend_d = 1'b0;
      ext_pend_d = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
      clk_prev_q <= 1'b1;
      code_q     <= 8'h00;
      sbrk_q     <= 1'b0;
      sext_q     <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      brk_pend_q <= brk_pend_d;
      ext_pend_q <= ext_pend_d;
      clk_prev_q <= clk_f_s;
      code_q     <= code_d;
      sbrk_q     <= sbrk_d;
      sext_q     <= sext_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign scan_code  = code_q;
  assign scan_valid = valid_q;
  assign scan_break = sbrk_q;
  assign scan_ext   = sext_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: a table of frames with expected decode,
// plus hand sequences for reset, glitch rejection and (optionally) timeout.
module tb_ps2_frame_rx;

  localparam int HALF   = 20;
  localparam int TO_CYC = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       scan_break;
  logic       scan_ext;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  ps2_frame_rx #(
    .CLK_HZ         (100_000_000),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .scan_break (scan_break),
    .scan_ext   (scan_ext),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Cumulative count of cycles each strobe is high, sampled mid-cycle.
  int valid_cyc = 0;
  int perr_cyc  = 0;
  int ferr_cyc  = 0;
  always @(negedge clk) begin
    if (scan_valid) valid_cyc++;
    if (parity_err) perr_cyc++;
    if (frame_err)  ferr_cyc++;
  end

  typedef struct {
    logic [7:0] code;
    logic       flip;
    logic       stop;
    int         e_valid;
    logic [7:0] e_code;
    logic       e_brk;
    logic       e_ext;
    int         e_perr;
    int         e_ferr;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip);
    send_bit(stop);
    ps2_data = 1'b1;
    wait_clk(3 * HALF);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int v0, p0, f0;
    v0 = valid_cyc;
    p0 = perr_cyc;
    f0 = ferr_cyc;
    send_frame(v.code, v.flip, v.stop);
    @(negedge clk);
    check({tag, ".valid_cycles"}, 32'(valid_cyc - v0), 32'(v.e_valid));
    check({tag, ".parity_err"},   32'(perr_cyc - p0),  32'(v.e_perr));
    check({tag, ".frame_err"},    32'(ferr_cyc - f0),  32'(v.e_ferr));
    check({tag, ".scan_code"},    32'(scan_code),      32'(v.e_code));
    check({tag, ".scan_break"},   32'(scan_break),     32'(v.e_brk));
    check({tag, ".scan_ext"},     32'(scan_ext),       32'(v.e_ext));
    check({tag, ".busy"},         32'(busy),           32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, p0, f0;
    //          code   flip  stop  val code   brk   ext   perr ferr
    vecs[0]  = '{8'h16, 1'b0, 1'b1, 1, 8'h16, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b1, 0, 8'h16, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{8'h1E, 1'b0, 1'b1, 1, 8'h1E, 1'b1, 1'b0, 0, 0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b1, 0, 8'h1E, 1'b1, 1'b0, 0, 0};
    vecs[4]  = '{8'hF0, 1'b0, 1'b1, 0, 8'h1E, 1'b1, 1'b0, 0, 0};
    vecs[5]  = '{8'h75, 1'b0, 1'b1, 1, 8'h75, 1'b1, 1'b1, 0, 0};
    vecs[6]  = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0, 0, 0};
    vecs[7]  = '{8'hF0, 1'b0, 1'b1, 0, 8'h1C, 1'b0, 1'b0, 0, 0};
    vecs[8]  = '{8'h1C, 1'b1, 1'b1, 0, 8'h1C, 1'b0, 1'b0, 1, 0};
    vecs[9]  = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0, 0, 0};
    vecs[10] = '{8'hE0, 1'b0, 1'b1, 0, 8'h1C, 1'b0, 1'b0, 0, 0};
    vecs[11] = '{8'h16, 1'b0, 1'b0, 0, 8'h1C, 1'b0, 1'b0, 0, 1};
    vecs[12] = '{8'h16, 1'b0, 1'b1, 1, 8'h16, 1'b0, 1'b0, 0, 0};
    vecs[13] = '{8'hE0, 1'b0, 1'b1, 0, 8'h16, 1'b0, 1'b0, 0, 0};
    vecs[14] = '{8'hE0, 1'b0, 1'b1, 0, 8'h16, 1'b0, 1'b0, 0, 0};
    vecs[15] = '{8'h6B, 1'b0, 1'b1, 1, 8'h6B, 1'b0, 1'b1, 0, 0};

    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(5);
    @(negedge clk);
    check("reset.scan_code",  32'(scan_code),  32'h00);
    check("reset.scan_valid", 32'(scan_valid), 32'd0);
    check("reset.scan_break", 32'(scan_break), 32'd0);
    check("reset.scan_ext",   32'(scan_ext),   32'd0);
    check("reset.parity_err", 32'(parity_err), 32'd0);
    check("reset.frame_err",  32'(frame_err),  32'd0);
    check("reset.busy",       32'(busy),       32'd0);
    rst_n = 1'b1;
    wait_clk(10);

    for (int i = 0; i < 16; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // A 2-cycle low glitch on ps2_clk with data low must not start a frame.
    ps2_data = 1'b0;
    wait_clk(10);
    ps2_clk = 1'b0;
    wait_clk(2);
    ps2_clk = 1'b1;
    wait_clk(20);
    @(negedge clk);
    check("glitch.busy", 32'(busy), 32'd0);
    ps2_data = 1'b1;
    wait_clk(20);

    // Reset after bit 5 of a 0x16 frame discards it without any strobe.
    v0 = valid_cyc;
    p0 = perr_cyc;
    f0 = ferr_cyc;
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_bit(vecs[0].code[i]);
    wait_clk(10);
    @(negedge clk);
    check("midrst.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    wait_clk(3);
    @(negedge clk);
    check("midrst.scan_code",  32'(scan_code),  32'h00);
    check("midrst.scan_break", 32'(scan_break), 32'd0);
    check("midrst.scan_ext",   32'(scan_ext),   32'd0);
    check("midrst.busy",       32'(busy),       32'd0);
    rst_n    = 1'b1;
    ps2_data = 1'b1;
    wait_clk(60);
    @(negedge clk);
    check("midrst.no_valid", 32'(valid_cyc - v0), 32'd0);
    check("midrst.no_perr",  32'(perr_cyc - p0),  32'd0);
    check("midrst.no_ferr",  32'(ferr_cyc - f0),  32'd0);
    apply_vec(vecs[0], "after_rst");

`ifdef PS2_RX_TIMEOUT_EN
    // Pending break, then a stalled frame: timeout must clear it.
    apply_vec(vecs[1], "to_f0");
    v0 = valid_cyc;
    f0 = ferr_cyc;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(vecs[2].code[i]);
    wait_clk(10);
    @(negedge clk);
    check("timeout.busy_stalled", 32'(busy), 32'd1);
    wait_clk(TO_CYC + 200);
    ps2_data = 1'b1;
    @(negedge clk);
    check("timeout.frame_err", 32'(ferr_cyc - f0),  32'd1);
    check("timeout.no_valid",  32'(valid_cyc - v0), 32'd0);
    check("timeout.busy",      32'(busy),           32'd0);
    apply_vec('{8'h1E, 1'b0, 1'b1, 1, 8'h1E, 1'b0, 1'b0, 0, 0}, "after_to");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
